// File: rtl/inst_queue_if.sv
// Fetch/issue interface of the instruction queue.
// An entry is a 67-bit vector laid out as {pc[31:0], instruction[31:0], prediction, branch, jump},
// so pc is [66:35], instruction [34:3], prediction [2], branch [1], jump [0].
// Signals:
//   pipe_in, in_valid : entry offered by fetch
//   enable            : back to fetch, 1 = fetch may advance and the queue accepts
//   flush             : redirect from commit, discards all entries
//   iq_out, out_valid : head entry presented to issue
//   out_ready         : issue accepts the head this cycle
//   count             : occupancy, 0..DEPTH
// Modports: slave = the queue, master = fetch/issue/commit side.
interface inst_queue_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH)
);
  logic [66:0]    pipe_in;
  logic           in_valid;
  logic           enable;
  logic           flush;
  logic [66:0]    iq_out;
  logic           out_valid;
  logic           out_ready;
  logic [PTR_W:0] count;

  modport slave (
    input  pipe_in, in_valid, flush, out_ready,
    output enable, iq_out, out_valid, count
  );

  modport master (
    output pipe_in, in_valid, flush, out_ready,
    input  enable, iq_out, out_valid, count
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and issue: circular FIFO of DEPTH entries with an in-order
// valid/ready head, back-pressure to fetch through enable, and a flush that empties the queue.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   iq    : inst_queue_if.slave (fetch entry in, stall out, flush, head entry to issue, count)
// Optional feature: define IQ_BYPASS_EN to let an entry arriving at an empty queue appear on
// iq_out in the same cycle (and be consumed without being stored if issue is ready).
module inst_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  inst_queue_if.slave  iq
);

  localparam logic [PTR_W:0] FullCnt = DEPTH[PTR_W:0];

  logic [66:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCnt);

`ifdef IQ_BYPASS_EN
  assign w_bypass = w_empty & iq.in_valid & ~iq.flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry taken by issue in the same cycle is never written.
  assign w_push = iq.in_valid & ~w_full & ~iq.flush & ~(w_bypass & iq.out_ready);
  // Pops from storage only; a bypass hand-off leaves the pointers alone.
  assign w_pop  = ~w_empty & iq.out_ready & ~iq.flush;

  always_comb begin
    iq.enable    = ~w_full;
    iq.out_valid = ~w_empty | w_bypass;
    iq.count     = r_count;
    iq.iq_out    = '0;
    if (w_bypass) begin
      iq.iq_out = iq.pipe_in;
    end else if (!w_empty) begin
      iq.iq_out = r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (iq.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; its contents are only observed when count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= iq.pipe_in;
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  localparam int unsigned Depth = 16;
`ifdef IQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err = 0;

  logic [66:0] model_q [$];

  inst_queue_if #(.DEPTH(Depth)) bus ();

  inst_queue #(.DEPTH(Depth)) dut (
    .clk   (clk),
    .reset (rst_n),
    .iq    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] mk(logic [31:0] pc, logic [31:0] ins, logic [2:0] pbj);
    return {pc, ins, pbj};
  endfunction

  task automatic chk(string name, logic [66:0] act, logic [66:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit iv, logic [66:0] e, bit fl, bit rdy);
    bus.in_valid  = iv;
    bus.pipe_in   = e;
    bus.flush     = fl;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of accepted entries. Inputs are stable at the negedge,
  // so the cycle's outcome is predicted there and compared with what the DUT presents.
  always @(negedge clk) begin
    int sz;
    bit acc;
    logic [66:0] exp_e;
    if (!rst_n) begin
      model_q.delete();
    end else begin
      sz = model_q.size();
      chk("count", 67'(bus.count), 67'(sz));
      chk("enable", 67'(bus.enable), 67'(sz != Depth));
      chk("out_valid", 67'(bus.out_valid),
          67'((sz != 0) || (Byp && bus.in_valid && !bus.flush)));
      if (bus.flush) begin
        model_q.delete();
      end else begin
        acc = bus.in_valid && (sz != Depth);
        if (acc) model_q.push_back(bus.pipe_in);
        if (bus.out_ready && ((sz != 0) || (Byp && acc))) begin
          exp_e = model_q.pop_front();
          chk("iq_out", bus.iq_out, exp_e);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.pipe_in = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_count", 67'(bus.count), 67'(0));
    chk("rst_out_valid", 67'(bus.out_valid), 67'(0));
    chk("rst_enable", 67'(bus.enable), 67'(1));
    chk("rst_iq_out", bus.iq_out, 67'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to full; the 17th entry must be ignored. Then drain in order.
    for (int i = 0; i < 17; i++) drive(1'b1, mk(32'(i * 4), 32'h13 + 32'(i), 3'(i)), 1'b0, 1'b0);
    chk("full_count", 67'(bus.count), 67'(Depth));
    chk("full_enable", 67'(bus.enable), 67'(0));
    for (int i = 0; i < 18; i++) drive(1'b0, '0, 1'b0, 1'b1);
    chk("drained_valid", 67'(bus.out_valid), 67'(0));

    // Full with simultaneous push attempt and pop, then continued streaming.
    for (int i = 0; i < 16; i++) drive(1'b1, mk(32'(i * 4), 32'hA0 + 32'(i), 3'b000), 1'b0, 1'b0);
    for (int i = 16; i < 24; i++) drive(1'b1, mk(32'(i * 4), 32'hA0 + 32'(i), 3'b001), 1'b0, 1'b1);
    chk("stream_count", 67'(bus.count), 67'(Depth - 1));
    for (int i = 0; i < 18; i++) drive(1'b0, '0, 1'b0, 1'b1);

    // Wrap: 40 pushes with 2 pops per 3 cycles, then drain.
    for (int i = 0; i < 40; i++)
      drive(1'b1, mk(32'h1000 + 32'(i * 4), $urandom, 3'($urandom)), 1'b0, (i % 3) != 0);
    for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b0, 1'b1);
    chk("wrap_final_count", 67'(bus.count), 67'(0));

    // Flush with a same-cycle push and pop.
    for (int i = 0; i < 5; i++) drive(1'b1, mk(32'h2000 + 32'(i * 4), 32'h33, 3'b010), 1'b0, 1'b0);
    drive(1'b1, mk(32'hDEAD_BEEF, 32'h44, 3'b111), 1'b1, 1'b1);
    chk("flush_count", 67'(bus.count), 67'(0));
    chk("flush_enable", 67'(bus.enable), 67'(1));
    chk("flush_valid", 67'(bus.out_valid), 67'(0));
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset between edges with 7 entries queued.
    for (int i = 0; i < 7; i++) drive(1'b1, mk(32'h3000 + 32'(i * 4), 32'h55, 3'b100), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 67'(bus.count), 67'(0));
    chk("arst_out_valid", 67'(bus.out_valid), 67'(0));
    chk("arst_enable", 67'(bus.enable), 67'(1));
    chk("arst_iq_out", bus.iq_out, 67'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Empty-queue arrival with issue ready: same-cycle only with bypass.
    bus.in_valid  = 1'b1;
    bus.pipe_in   = mk(32'h100, 32'h0000_006F, 3'b001);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("byp_same_valid", 67'(bus.out_valid), 67'(Byp));
    if (Byp) chk("byp_same_jump", 67'(bus.iq_out[0]), 67'(1));
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("byp_next_count", 67'(bus.count), 67'(!Byp));
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Random traffic with occasional flushes.
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, mk(pc, $urandom, 3'($urandom)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
      pc += 4;
    end
    for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b0, 1'b1);
    chk("final_count", 67'(bus.count), 67'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction queue between fetch and issue.
- Consumer end of the fetch output interface: accepts one pipe_in_t entry per cycle from fetch and drives the fetch `enable` (stall) signal back.
- Buffers entries in a circular FIFO and presents them in order to issue with a valid/ready handshake.
- Flushes all contents on a branch/jump redirect.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- pipe_in  input  pipe_in_t (67)  fetch entry; fields pc[31:0], instruction[31:0], prediction, branch, jump.
- in_valid  input  1  fetch presents a valid entry this cycle.
- enable  output  1  to fetch; 1 = fetch may advance and queue accepts.
- flush  input  1  redirect/mispredict from commit; discard all entries.
- iq_out  output  pipe_in_t (67)  head entry to issue.
- out_valid  output  1  iq_out holds a valid entry.
- out_ready  input  1  issue accepts the head this cycle.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, async): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, enable=1, iq_out=0. Storage contents don't care.
- Write (push) = in_valid & enable & ~flush.
  - Entry stored at wr_ptr on the clock edge.
  - wr_ptr increments modulo DEPTH.
- Read (pop) = out_valid & out_ready & ~flush. rd_ptr increments modulo DEPTH.
- iq_out = mem[rd_ptr], combinational from registered state.
  - Head data appears one cycle after it is written into an empty queue.
  - Exception: bypass mode, see Optional Feature.
- out_valid = (count != 0). enable = (count != DEPTH). Both are combinational from registered count.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Full with pop: enable=0, so no push that cycle. The pop frees a slot, and enable rises the next cycle.
- Pointer wrap: DEPTH-1 -> 0. Full vs empty is distinguished by count, never by pointer equality.
- Flush has priority over everything, same cycle:
  - Next state: wr_ptr=rd_ptr=0, count=0.
  - Same-cycle push and pop are suppressed.
  - out_valid may be high during the flush cycle, but issue must ignore it (flush gates pop).
  - enable=1 on the cycle after flush.
- Overflow and underflow are impossible by construction. An in_valid while enable=0 is ignored; fetch holds its entry.
- Reset mid-operation: asynchronous clear to the reset state regardless of any other input.
- Entries pass through unmodified. No field is recomputed (prediction, branch, jump as produced by fetch).

Optional Feature:
- Macro IQ_BYPASS_EN.
- Defined: when count==0 and in_valid & ~flush:
  - iq_out = pipe_in and out_valid=1 combinationally, same cycle.
  - If out_ready=1, the entry is consumed without being written; count stays 0, pointers unchanged.
  - If out_ready=0, the entry is written normally.
- Undefined: no combinational path from pipe_in/in_valid to iq_out/out_valid; minimum latency is 1 cycle.

Test Plan:
- Reset then fill: out_ready=0, push 16 entries with pc=0x0,0x4,..,0x3C -> count=16 after 16 edges, enable=0 on cycle 16, 17th in_valid ignored; drain yields pc 0x0..0x3C in order, then out_valid=0.
- Simultaneous push/pop at full: count=16, out_ready=1, in_valid=1 -> pop pc 0x0, no push, count=15, enable=1 next cycle; following push accepted, count stays 15 with continued pop.
- Wrap: 40 entries streamed with 2 pops per 3 pushes, draining at end -> order preserved across pointer wrap, count never exceeds 16, final count=0.
- Flush: queue holds 5 entries, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, enable=1; the flushed-cycle entry is never presented.
- Async reset mid-stream: count=7, drop reset between edges -> count=0, out_valid=0, enable=1 immediately, before any clock edge.
- Bypass (IQ_BYPASS_EN): empty queue, in_valid=1, pc=0x100, instruction=0x0000006F, out_ready=1 -> same-cycle iq_out.pc=0x100, iq_out.jump=1, out_valid=1, count stays 0. Without the macro -> out_valid=0 that cycle, 1 the next.
